alu_iter_exec: RTL and testbench
================================

// Module: alu_iter_exec
// PURPOSE
//   Multi-cycle execute unit; consumes the 4-bit ALUCtrl code from the ALU decoder plus SrcA/SrcB.
//   Sits between decode/operand fetch and writeback; valid/ready on both sides.
//   Logic/add/compare ops: 1 cycle. Shifts: iterative, 1 bit/cycle. Optional iterative multiply.
// PARAMETERS
//   WIDTH      32   datapath width; shift amount = SrcB[$clog2(WIDTH)-1:0]
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operation presented
//   in_ready   out  1      unit can accept; high only in IDLE and rst low
//   ALUCtrl    in   4      op code (table below)
//   SrcA       in   WIDTH  operand A
//   SrcB       in   WIDTH  operand B
//   out_valid  out  1      ALUResult/Zero valid; held until out_ready
//   out_ready  in   1      consumer accepts result
//   ALUResult  out  WIDTH  registered result
//   Zero       out  1      registered (ALUResult == 0)
// BEHAVIOUR
//   Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA,
//     1000 SLT (signed), 1001 SLTU; 1010 MUL (macro only); all other codes -> ADD.
//   SLT/SLTU result = {WIDTH-1 zeros, lt}. ADD/SUB wrap modulo 2^WIDTH, no overflow flag.
//   Reset: state IDLE, out_valid 0, ALUResult 0, Zero 0, counters 0; in_ready 0 while rst high.
//   Accept = in_valid & in_ready (cycle N). Operands/code captured; inputs ignored afterwards.
//   States: IDLE, SHIFT, MUL, DONE.
//     IDLE: accept, single-cycle op -> compute into ALUResult, go DONE (out_valid at N+1).
//     IDLE: accept, shift -> acc=SrcA, cnt=shamt; shamt==0 -> DONE, ALUResult=SrcA (N+1);
//       else SHIFT.
//     SHIFT: acc shifts 1 bit/cycle (SRA replicates MSB), cnt--; at cnt==1 go DONE.
//       out_valid at N+1+shamt.
//     MUL: see CONFIGURATION.
//     DONE: out_valid=1; ALUResult/Zero stable; out_ready -> IDLE next cycle (in_ready re-asserts).
//   No accept in DONE: max throughput 1 op / 2 cycles. out_valid & out_ready in same cycle
//     counts as consumed.
//   out_ready held low: stay in DONE indefinitely, outputs unchanged.
//   Zero computed from the final value written to ALUResult, same cycle it is written.
//   rst mid-operation (any state): abort, discard partial result, return to reset values next edge.
//   in_valid toggling while busy: no effect; no op is queued or lost-tracked.
// CONFIGURATION
//   ALU_ITER_MUL_EN defined: code 1010 = MUL, low WIDTH bits of SrcA*SrcB (sign-agnostic);
//     shift-add, one multiplier bit/cycle over WIDTH cycles in state MUL; out_valid at N+1+WIDTH.
//   ALU_ITER_MUL_EN undefined: no MUL state or multiplier logic; 1010 decodes as ADD (1 cycle).
// TESTING
//   Reset mid-SHIFT (SLL, shamt=20, rst at N+5) -> out_valid never rises; in_ready=1 cycle after rst.
//   ADD 0xFFFFFFFF + 0x1 accepted at N -> N+1 out_valid=1, ALUResult=0, Zero=1.
//   SRA SrcA=0x80000000, SrcB=4 -> out_valid at N+5, ALUResult=0xF8000000; in_ready=0 N+1..N+5.
//   SLT 0xFFFFFFFE vs 0x1 -> 1; SLTU same operands -> 0, Zero=1; code 1111 with 3,4 -> 7.
//   SLL shamt=0 (SrcB=0x20) -> out_valid at N+1, ALUResult=SrcA; hold out_ready=0 for 10 cycles
//     -> result stable.
//   MUL 0xFFFFFFFF*0x3 -> 0xFFFFFFFD at N+33 with macro; without macro -> 0x00000002 at N+1.

Source files
------------

// File: rtl/alu_iter_exec.sv
// ============================================================================
// alu_iter_exec : multi-cycle execute unit (1-cycle logic/add/compare ops, 1 bit/cycle shifts);
//                 define ALU_ITER_MUL_EN to add an iterative shift-add multiply on code 1010.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module alu_iter_exec #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUCtrl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
`ifdef ALU_ITER_MUL_EN
      , S_MUL = 2'd3
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       shop_q, shop_d;
`ifdef ALU_ITER_MUL_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] mul_sum;
`endif

   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] sh_next;
   logic [SHW-1:0]   shamt;
   logic             is_shift;

   assign shamt     = SrcB[SHW-1:0];
   assign is_shift  = (ALUCtrl == 4'b0101) || (ALUCtrl == 4'b0110) || (ALUCtrl == 4'b0111);
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign ALUResult = result_q;
   assign Zero      = zero_q;

   always_comb begin
      alu_res = SrcA + SrcB;
      case (ALUCtrl)
         4'b0001: alu_res = SrcA - SrcB;
         4'b0010: alu_res = SrcA & SrcB;
         4'b0011: alu_res = SrcA | SrcB;
         4'b0100: alu_res = SrcA ^ SrcB;
         4'b1000: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
         default: alu_res = SrcA + SrcB;
      endcase
   end

   // shop_q holds ALUCtrl[1:0]: 01 SLL, 10 SRL, 11 SRA
   always_comb begin
      case (shop_q)
         2'b01:   sh_next = acc_q << 1;
         2'b10:   sh_next = acc_q >> 1;
         default: sh_next = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      endcase
   end

`ifdef ALU_ITER_MUL_EN
   assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      result_d = result_q;
      zero_d   = zero_q;
      cnt_d    = cnt_q;
      shop_d   = shop_q;
`ifdef ALU_ITER_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_shift) begin
                  acc_d  = SrcA;
                  cnt_d  = {1'b0, shamt};
                  shop_d = ALUCtrl[1:0];
                  if (shamt == '0) begin
                     result_d = SrcA;
                     zero_d   = (SrcA == '0);
                     state_d  = S_DONE;
                  end else begin
                     state_d  = S_SHIFT;
                  end
`ifdef ALU_ITER_MUL_EN
               end else if (ALUCtrl == 4'b1010) begin
                  acc_d    = '0;
                  mcand_d  = SrcA;
                  mplier_d = SrcB;
                  cnt_d    = CW'(WIDTH);
                  state_d  = S_MUL;
`endif
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  state_d  = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            acc_d = sh_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               result_d = sh_next;
               zero_d   = (sh_next == '0);
               state_d  = S_DONE;
            end
         end
`ifdef ALU_ITER_MUL_EN
         S_MUL: begin
            acc_d    = mul_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               result_d = mul_sum;
               zero_d   = (mul_sum == '0);
               state_d  = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cnt_q    <= '0;
         shop_q   <= '0;
`ifdef ALU_ITER_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cnt_q    <= cnt_d;
         shop_q   <= shop_d;
`ifdef ALU_ITER_MUL_EN
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_iter_exec.sv
// ============================================================================
// tb_alu_iter_exec : scoreboard bench for alu_iter_exec with directed vectors.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_alu_iter_exec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  ALUCtrl = 4'd0;
   logic [31:0] SrcA = 32'd0;
   logic [31:0] SrcB = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] ALUResult;
   logic        Zero;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] res;
      logic        z;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   held = 1'b0;

   alu_iter_exec #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUCtrl   (ALUCtrl),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Zero      (Zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor: compares on the first cycle of each out_valid, then checks stability while held
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1) begin
         if (!held) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out_valid actual=0x%08h required=no output (cycle %0d)",
                        ALUResult, cyc);
            end else begin
               cur = exp_q.pop_front();
               chk("result", ALUResult, cur.res);
               chk("zero", {31'd0, Zero}, {31'd0, cur.z});
               chk("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
            end
            held = 1'b1;
         end else begin
            chk("held_result", ALUResult, cur.res);
            chk("held_zero", {31'd0, Zero}, {31'd0, cur.z});
         end
         if (out_ready) held = 1'b0;
      end
   end

   // present one op, wait (bounded) for acceptance, then scramble inputs while busy
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int lat);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      in_valid = 1'b1; ALUCtrl = c; SrcA = a; SrcB = b;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         chk("accept_timeout", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         return;
      end
      e.res = er; e.z = (er == 32'd0); e.lat = lat; e.acc_cyc = cyc;
      exp_q.push_back(e);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         in_valid = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
         ALUCtrl  = 4'($urandom);
         SrcA     = $urandom;
         SrcB     = $urandom;
         @(negedge clk);
         chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", ALUResult, 32'd0);
      chk("rst_zero", {31'd0, Zero}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      issue(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
      issue(4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1);
      issue(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
      issue(4'b0011, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1);
      issue(4'b0100, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1);
      issue(4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5);
      issue(4'b0110, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5);
      issue(4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32);
      issue(4'b0110, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 2);
      issue(4'b1000, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1);
      issue(4'b1001, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1);
      issue(4'b1111, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1);
      issue(4'b1011, 32'h0000_000A, 32'h0000_0014, 32'h0000_001E, 1);
`ifdef ALU_ITER_MUL_EN
      issue(4'b1010, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33);
`else
      issue(4'b1010, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 1);
`endif

      // shamt 0 with a held-off consumer: result must stay put
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(4'b0101, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1);
      repeat (10) @(posedge clk);
      #1;
      out_ready = 1'b1;

      // reset during SHIFT: no output may ever appear
      @(posedge clk); #1;
      in_valid = 1'b1; ALUCtrl = 4'b0101; SrcA = 32'h0000_0003; SrcB = 32'd20;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_test_accept", {31'd0, in_ready}, 32'd1);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
      chk("result_after_rst", ALUResult, 32'd0);
      chk("valid_after_rst", {31'd0, out_valid}, 32'd0);
      repeat (30) @(posedge clk);

      // one more op after the abort to confirm normal service resumes
      issue(4'b0000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1);

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
